// File: rtl/led_pkg.sv
// Shared definitions for the LED display path: the feeder FSM state encoding,
// the display digit count, the decimal saturation limit and the nibble width.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    SETUP  = 2'd2,
    STROBE = 2'd3
  } led_state_e;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned MAX_VALUE = 9999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble that is 5 or more, so
// that the following left shift carries correctly into the next decimal digit.
// Ports:
//   i_nibble  one BCD digit of the accumulator
//   o_nibble  corrected digit (i_nibble >= 5 ? i_nibble + 3 : i_nibble)
module bcd_add3
  import led_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_nibble,
  output logic [NIBBLE_W-1:0] o_nibble
);

  always_comb begin
    o_nibble = i_nibble;
    if (i_nibble >= NIBBLE_W'(5)) begin
      o_nibble = i_nibble + NIBBLE_W'(3);
    end
  end

endmodule

// File: rtl/led_bcd_feeder.sv
// Feeder for the 4-digit 7-segment display. Takes a binary value over a
// valid/ready handshake, converts it to packed BCD with an iterative
// double-dabble engine (or passes it through as hex), then presents it on the
// display bus with an enable and a one-cycle write strobe.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   in_valid       request strobe; in_ready high only while idle
//   in_value       binary value, in_hex selects raw hex display
//   data_out       packed digits, nibble 0 is the rightmost digit
//   disp_enable    display select, disp_write one-cycle write pulse
//   overflow       last decimal request was clamped to MAX_VALUE
//   busy           inverse of in_ready
module led_bcd_feeder #(
  parameter int unsigned BIN_W     = 16,
  parameter int unsigned DIGITS    = led_pkg::DIGITS,
  parameter int unsigned MAX_VALUE = led_pkg::MAX_VALUE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_value,
  input  logic                  in_hex,
  output logic [4*DIGITS-1:0]   data_out,
  output logic                  disp_enable,
  output logic                  disp_write,
  output logic                  overflow,
  output logic                  busy
);

  import led_pkg::*;

  localparam int unsigned BCD_W = NIBBLE_W * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  led_state_e         r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [BCD_W-1:0]   r_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_en;
  logic               r_wr;
  logic               r_ovf;

  logic [BCD_W-1:0]   w_adj;
  logic               w_over;
  logic [BIN_W-1:0]   w_clamped;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nibble (r_bcd[g*NIBBLE_W +: NIBBLE_W]),
      .o_nibble (w_adj[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  assign w_over    = (in_value > BIN_W'(MAX_VALUE));
  assign w_clamped = w_over ? BIN_W'(MAX_VALUE) : in_value;

  // Display outputs are registered and so trail the state by one cycle:
  // leaving SETUP raises enable with the data, leaving STROBE raises write,
  // and the first IDLE cycle drops both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_wr    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_en <= 1'b0;
          r_wr <= 1'b0;
          if (in_valid) begin
            r_cnt <= '0;
            if (in_hex) begin
              r_bcd   <= BCD_W'(in_value);
              r_ovf   <= 1'b0;
              r_state <= SETUP;
            end else begin
              r_bcd   <= '0;
              r_bin   <= w_clamped;
              r_ovf   <= w_over;
              r_state <= CONV;
            end
          end
        end
        CONV: begin
          // High bits shifted out of the accumulator are dropped; clamping
          // guarantees they are zero.
          r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          r_bin <= {r_bin[BIN_W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_data  <= r_bcd;
          r_en    <= 1'b1;
          r_state <= STROBE;
        end
        STROBE: begin
          r_wr    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign busy        = ~in_ready;
  assign data_out    = r_data;
  assign disp_enable = r_en;
  assign disp_write  = r_wr;
  assign overflow    = r_ovf;

endmodule
